btn_event: RTL and testbench
============================

BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the tick-counter width in bits.
REQ-002 The block SHALL have parameter LONG_TICKS, default 50, giving the ticks held before a long press; legal range is 1..2^W-1.
REQ-003 The block SHALL have parameter DBL_TICKS, default 20, giving the release window in ticks for a second press; legal range is 1..2^W-1.
REQ-004 The block SHALL have parameter REPEAT_TICKS, default 10, giving the auto-repeat period in ticks; it is used only with the macro of REQ-020.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port fall, input, 1 bit: single-cycle press strobe from the upstream filter.
REQ-008 The block SHALL have port rise, input, 1 bit: single-cycle release strobe from the upstream filter.
REQ-009 The block SHALL have port tick, input, 1 bit: single-cycle timebase strobe.
REQ-010 The block SHALL have outputs evt_short, evt_long, evt_double and evt_repeat, each 1 bit: single-cycle registered event pulses.
REQ-011 The block SHALL have output busy, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, PRESS1, WAIT2, PRESS2 and HELD, plus one W-bit counter cnt; cnt increments only on cycles where tick=1.
REQ-013 In IDLE, fall SHALL cause the transition to PRESS1 with cnt=0; rise and tick SHALL be ignored, so a button held through reset produces no event until it is released and pressed again.
REQ-014 In PRESS1, rise SHALL cause the transition to WAIT2 with cnt=0; a tick that makes cnt reach LONG_TICKS SHALL pulse evt_long and cause the transition to HELD.
REQ-015 In WAIT2, fall SHALL cause the transition to PRESS2 with cnt=0; a tick that makes cnt reach DBL_TICKS SHALL pulse evt_short and cause the transition to IDLE.
REQ-016 In PRESS2, rise SHALL pulse evt_double and cause the transition to IDLE; a tick that makes cnt reach LONG_TICKS SHALL pulse evt_long, suppress evt_double and cause the transition to HELD.
REQ-017 In HELD, rise SHALL cause the transition to IDLE with no event.
REQ-018 Timing and ordering: every event pulse SHALL be asserted in the cycle after the causing input; an edge (rise/fall) coinciding with a timeout tick SHALL take priority over the timeout; rise and fall together SHALL be treated as rise; at most one evt_* SHALL be high in any cycle.
REQ-019 cnt SHALL saturate at all-ones and never wrap.

Configuration
REQ-020 With macro BTN_EVENT_REPEAT_EN defined, HELD SHALL reload cnt=0 on entry and pulse evt_repeat each time a tick makes cnt reach REPEAT_TICKS, then set cnt=0; without the macro, evt_repeat SHALL be tied to 0 and no repeat logic shall exist.

Reset
REQ-021 While rst_n=0, the FSM SHALL be IDLE, cnt SHALL be 0, and all evt_* and busy SHALL be 0, asynchronously.
REQ-022 Reset deassertion mid-press SHALL resume in IDLE with no spurious event.

Verification
Bench parameters: LONG_TICKS=10, DBL_TICKS=4, REPEAT_TICKS=3, tick=1 every cycle unless stated.
REQ-023 Short press: fall at cycle 0, rise at cycle 5 -> single evt_short at cycle 10; busy falls at the same cycle.
REQ-024 Double press: fall at 0, rise at 3, fall at 5, rise at 8 -> single evt_double at cycle 9; no evt_short.
REQ-025 Long press with macro: fall at 0, rise at 20 -> evt_long at cycle 11, evt_repeat at cycles 14 and 17, then no event after the rise.
REQ-026 Long press without macro: same stimulus as REQ-025 -> evt_long only; evt_repeat stays 0.
REQ-027 Priority: rise in the same cycle as the cnt=10 tick in PRESS1 -> no evt_long; a short press completes instead.
REQ-028 Reset and held-at-reset: assert rst_n=0 in PRESS1, release, then rise -> no events; a subsequent full short press reports normally.

Source files
------------

// File: rtl/btn_event.sv
// Button event classifier: turns debounced press/release strobes into short, long and
// double-press pulses. Define BTN_EVENT_REPEAT_EN to add auto-repeat pulses while held.
`timescale 1ns/1ps

module btn_event #(
    parameter int W            = 8,
    parameter int LONG_TICKS   = 50,
    parameter int DBL_TICKS    = 20,
    parameter int REPEAT_TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fall,
    input  logic rise,
    input  logic tick,
    output logic evt_short,
    output logic evt_long,
    output logic evt_double,
    output logic evt_repeat,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HELD
    } state_t;

    localparam logic [W-1:0] LONG_T = W'(LONG_TICKS);
    localparam logic [W-1:0] DBL_T  = W'(DBL_TICKS);

    // Elaboration-time guard on the tick thresholds.
    if (LONG_TICKS < 1 || LONG_TICKS > (2**W) - 1) begin : g_bad_long
        $error("btn_event: LONG_TICKS out of range for W");
    end
    if (DBL_TICKS < 1 || DBL_TICKS > (2**W) - 1) begin : g_bad_dbl
        $error("btn_event: DBL_TICKS out of range for W");
    end
    if (REPEAT_TICKS < 1 || REPEAT_TICKS > (2**W) - 1) begin : g_bad_rep
        $error("btn_event: REPEAT_TICKS out of range for W");
    end

    state_t         state;
    logic [W-1:0]   cnt;
    logic [W-1:0]   cnt_inc;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign cnt_inc = (&cnt) ? cnt : cnt + W'(1);

`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [W-1:0] REPEAT_T = W'(REPEAT_TICKS);
`else
    assign evt_repeat = 1'b0;
`endif

    // NOTE: all state and outputs live in one clocked block and use non-blocking
    // assignments, so every branch reads the pre-edge values of state and cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            evt_short  <= 1'b0;
            evt_long   <= 1'b0;
            evt_double <= 1'b0;
            busy       <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
            evt_repeat <= 1'b0;
`endif
        end else begin
            evt_short  <= 1'b0;
            evt_long   <= 1'b0;
            evt_double <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
            evt_repeat <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // A release seen here belongs to a press we never saw (e.g. held through reset).
                    if (fall && !rise) begin
                        state <= PRESS1;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                PRESS1: begin
                    if (rise) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt_inc == LONG_T) begin
                            evt_long <= 1'b1;
                            state    <= HELD;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                WAIT2: begin
                    // Any edge consumes the cycle; only a clean press starts the second click.
                    if (fall || rise) begin
                        if (!rise) begin
                            state <= PRESS2;
                            cnt   <= '0;
                        end
                    end else if (tick) begin
                        if (cnt_inc == DBL_T) begin
                            evt_short <= 1'b1;
                            state     <= IDLE;
                            cnt       <= '0;
                            busy      <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                PRESS2: begin
                    if (rise) begin
                        evt_double <= 1'b1;
                        state      <= IDLE;
                        cnt        <= '0;
                        busy       <= 1'b0;
                    end else if (tick) begin
                        if (cnt_inc == LONG_T) begin
                            evt_long <= 1'b1;
                            state    <= HELD;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                HELD: begin
                    if (rise) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (tick) begin
`ifdef BTN_EVENT_REPEAT_EN
                        if (cnt_inc == REPEAT_T) begin
                            evt_repeat <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
`else
                        cnt <= cnt_inc;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event.sv
// Self-checking bench for btn_event: per-cycle stimulus/expectation bitmasks, expected
// outputs queued at drive time and compared one cycle later, plus a mid-press reset sequence.
`timescale 1ns/1ps

module tb_btn_event;

    logic clk = 1'b0;
    logic rst_n;
    logic fall;
    logic rise;
    logic tick;
    logic evt_short;
    logic evt_long;
    logic evt_double;
    logic evt_repeat;
    logic busy;

    btn_event #(
        .W            (8),
        .LONG_TICKS   (10),
        .DBL_TICKS    (4),
        .REPEAT_TICKS (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fall       (fall),
        .rise       (rise),
        .tick       (tick),
        .evt_short  (evt_short),
        .evt_long   (evt_long),
        .evt_double (evt_double),
        .evt_repeat (evt_repeat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Bit k of an input mask is the input during cycle k; bit k of an output mask is the
    // value expected during cycle k (registered at the edge closing cycle k-1).
    typedef struct {
        string       name;
        int          n;
        logic [31:0] fall;
        logic [31:0] rise;
        logic [31:0] tick;
        logic [31:0] e_short;
        logic [31:0] e_long;
        logic [31:0] e_double;
        logic [31:0] e_repeat;
        logic [31:0] e_busy;
        logic [31:0] rep_dc;
    } vec_t;

    typedef struct {
        string     name;
        logic [4:0] exp;
        logic [4:0] care;
    } sb_t;

`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [31:0] LONG_REP = 32'h0002_4000;  // cycles 14 and 17
    localparam logic [31:0] LONG_DC  = 32'h0010_0000;  // cycle 20 coincides with the release
`else
    localparam logic [31:0] LONG_REP = 32'h0000_0000;
    localparam logic [31:0] LONG_DC  = 32'h0000_0000;
`endif

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [4:0] outs();
        return {evt_short, evt_long, evt_double, evt_repeat, busy};
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp,
                         input logic [4:0] care);
        n_cmp++;
        if (((got ^ exp) & care) != 5'b0) begin
            n_bad++;
            $display("FAIL %s: got s/l/d/r/busy=%b required %b (care %b)", name, got, exp, care);
        end
    endtask

    function automatic vec_t mk(input string name, input int n, input logic [31:0] f,
                                input logic [31:0] r, input logic [31:0] t,
                                input logic [31:0] es, input logic [31:0] el,
                                input logic [31:0] ed, input logic [31:0] er,
                                input logic [31:0] eb, input logic [31:0] dc);
        vec_t v;
        v.name = name; v.n = n; v.fall = f; v.rise = r; v.tick = t;
        v.e_short = es; v.e_long = el; v.e_double = ed; v.e_repeat = er;
        v.e_busy = eb; v.rep_dc = dc;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        sb_t e;
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            fall = v.fall[k];
            rise = v.rise[k];
            tick = v.tick[k];
            e.name = $sformatf("%s@%0d", v.name, k + 1);
            e.exp  = {v.e_short[k+1], v.e_long[k+1], v.e_double[k+1], v.e_repeat[k+1],
                      v.e_busy[k+1]};
            e.care = ~{3'b000, v.rep_dc[k+1], 1'b0};
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check(e.name, outs(), e.exp, e.care);
        end
        @(negedge clk);
        fall = 1'b0;
        rise = 1'b0;
        tick = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            fall = 1'b0;
            rise = 1'b0;
            tick = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fall  = 1'b0;
        rise  = 1'b0;
        tick  = 1'b1;

        //        name            n   fall          rise          tick          short         long          double        repeat    busy          rep_dc
        vecs.push_back(mk("short",      12, 32'h1,       32'h20,       ALL,          32'h400,      32'h0,        32'h0,        32'h0,    32'h3FE,      32'h0));
        vecs.push_back(mk("double",     12, 32'h21,      32'h108,      ALL,          32'h0,        32'h0,        32'h200,      32'h0,    32'h1FE,      32'h0));
        vecs.push_back(mk("long",       24, 32'h1,       32'h10_0000,  ALL,          32'h0,        32'h800,      32'h0,        LONG_REP, 32'h1F_FFFE,  LONG_DC));
        vecs.push_back(mk("rise_vs_to", 17, 32'h1,       32'h400,      ALL,          32'h8000,     32'h0,        32'h0,        32'h0,    32'h7FFE,     32'h0));
        vecs.push_back(mk("fall_vs_to", 12, 32'h41,      32'h104,      ALL,          32'h0,        32'h0,        32'h200,      32'h0,    32'h1FE,      32'h0));
        vecs.push_back(mk("rise_fall",  11, 32'h9,       32'h8,        ALL,          32'h100,      32'h0,        32'h0,        32'h0,    32'hFE,       32'h0));
        vecs.push_back(mk("press2_long",18, 32'h5,       32'h8002,     ALL,          32'h0,        32'h2000,     32'h0,        32'h0,    32'hFFFE,     32'h0));
        vecs.push_back(mk("slow_tick",  12, 32'h1,       32'h2,        32'h5555_5555,32'h200,      32'h0,        32'h0,        32'h0,    32'h1FE,      32'h0));
        vecs.push_back(mk("idle_rise",   5, 32'h0,       32'h1,        ALL,          32'h0,        32'h0,        32'h0,        32'h0,    32'h0,        32'h0));

        #2;
        check("reset_async", outs(), 5'b0, 5'h1F);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", outs(), 5'b0, 5'h1F);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            idle_cycles(3);
        end

        // Reset in the middle of a press, then the release of that press must be ignored.
        run_vec(mk("pre_reset", 3, 32'h1, 32'h0, ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'hE, 32'h0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_midpress", outs(), 5'b0, 5'h1F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk("held_release", 6, 32'h0, 32'h1, ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0));
        idle_cycles(2);
        run_vec(mk("short_after_rst", 12, 32'h1, 32'h20, ALL, 32'h400, 32'h0, 32'h0, 32'h0, 32'h3FE, 32'h0));

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
